// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and types for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibble counter width; a one-nibble adder still gets a 1-bit counter.
  function automatic int cnt_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_nibble_add4.sv
// Combinational 4-bit ripple-carry stage built from 1-bit full-adder cells.
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s4[i]   = a4[i] ^ b4[i] ^ c[i];
    assign c[i+1]  = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder feeding one 4-bit ripple stage a nibble per clock.
// Optional subtract mode: define NIBBLE_SERIAL_ADDER_SUB_EN to add the 'sub' port.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*NIBBLES-1:0]  a,
  input  logic [4*NIBBLES-1:0]  b,
  input  logic                  cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*NIBBLES-1:0]  sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = cnt_w(NIBBLES);

  state_t          state, state_nx;
  logic [W-1:0]    a_sr, b_sr, res_sr;
  logic [CW-1:0]   cnt;
  logic            cy, a_msb, b_msb;
  logic [W-1:0]    b_ld;
  logic            c_ld;
  logic [NIBBLE_W-1:0] s4;
  logic            co;
  logic            last;
  logic [W+NIBBLE_W-1:0] res_cat;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + 1; cin is ignored while subtracting.
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  nibble_add4 u_add4 (
    .a4 (a_sr[NIBBLE_W-1:0]),
    .b4 (b_sr[NIBBLE_W-1:0]),
    .ci (cy),
    .s4 (s4),
    .co (co)
  );

  assign last    = (cnt == CW'(NIBBLES - 1));
  // New nibble enters at the top; the concat keeps this legal for NIBBLES=1.
  assign res_cat = {s4, res_sr};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_sr   <= a;
          b_sr   <= b_ld;
          cy     <= c_ld;
          cnt    <= '0;
          res_sr <= '0;
          a_msb  <= a[W-1];
          b_msb  <= b_ld[W-1];
        end
        ST_RUN: begin
          res_sr <= res_cat[W+NIBBLE_W-1:NIBBLE_W];
          cy     <= co;
          a_sr   <= a_sr >> NIBBLE_W;
          b_sr   <= b_sr >> NIBBLE_W;
          cnt    <= cnt + CW'(1);
          // Result registers only move on the final nibble so they hold otherwise.
          if (last) begin
            sum  <= res_cat[W+NIBBLE_W-1:NIBBLE_W];
            cout <= co;
            ovf  <= (a_msb == b_msb) && (res_cat[W+NIBBLE_W-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized scoreboard bench for nibble_serial_adder (NIBBLES=4).
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_done = 0;
  int   n_acc  = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow from the signed range.
  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic ci, input logic si);
    exp_t         e;
    logic [W-1:0] bb;
    longint       c, u, s;
    bb = si ? ~bi : bi;
    c  = si ? 1 : longint'(ci);
    u  = longint'(ai) + longint'(bb) + c;
    s  = longint'($signed(ai)) + longint'($signed(bb)) + c;
    e.sum  = u[W-1:0];
    e.cout = u[W];
    e.ovf  = (s > 32767) || (s < -32768);
    e.acc  = 0;
    return e;
  endfunction

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout", 1, 0);
  endtask

  // Present one request on an IDLE cycle; expectation queued for the monitor.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, input logic si);
    exp_t e;
    wait_idle();
    a   = ai;
    b   = bi;
    cin = ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub = si;
`endif
    start = 1'b1;
    e     = model(ai, bi, ci, si);
    e.acc = cyc + 1;
    sb.push_back(e);
    n_acc++;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // DONE is the (NIBBLES+1)th cycle after the accepting edge: NIBBLES edges later.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sum",     sum,  mon_e.sum);
        check("cout",    cout, mon_e.cout);
        check("ovf",     ovf,  mon_e.ovf);
        check("latency", cyc - mon_e.acc, NIBBLES);
        check("busy_in_done", busy, 1);
      end
    end
  end

  initial begin
    int k, t;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum",  sum,  0);
      check("rst_cout", cout, 0);
      check("rst_ovf",  ovf,  0);
    end

    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);

    // Second request lands in RUN and must be dropped.
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    #1 begin a = 16'hAAAA; b = 16'h5555; start = 1'b1; end
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Abort in RUN cycle 2; the queued expectation is discarded.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    n_acc--;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum",  sum,  0);
    issue(16'h0003, 16'h0004, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    repeat (10) issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
`endif

    repeat (30) issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // start held high: a new operation on every IDLE cycle.
    wait_idle();
    start = 1'b1;
    k = 0;
    t = 0;
    while (k < 4 && t < 200) begin
      if (!busy) begin
        exp_t e;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        e     = model(a, b, cin, 1'b0);
        e.acc = cyc + 1;
        sb.push_back(e);
        n_acc++;
        k++;
      end
      if (k < 4) begin
        @(negedge clk);
        t++;
      end
    end
    if (t >= 200) check("held_timeout", 1, 0);
    @(posedge clk);
    #1 start = 1'b0;

    wait_idle();
    repeat (3) @(negedge clk);
    check("done_count", n_done, n_acc);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
